// File: rtl/periph_bus_bridge_if.sv
// CPU-port and slot-side signal bundle for the peripheral bus bridge.
// Latency: none, wires only.
// Backpressure: slots stall the CPU through slot_ack; the CPU waits for cpu_ready.
interface periph_bus_bridge_if #(
  parameter int NUM_SLOTS  = 8,
  parameter int DATA_WIDTH = 32
);
  // CPU side
  logic                            ce;
  logic                            rw;
  logic [3:0]                      periph_address;
  logic [3:0]                      reg_address;
  logic [DATA_WIDTH-1:0]           data_in;
  logic [DATA_WIDTH-1:0]           data_out;
  logic                            cpu_ready;
  logic                            bus_err;
  // Slot side
  logic [NUM_SLOTS-1:0]            slot_ce;
  logic                            slot_rw;
  logic [3:0]                      slot_reg_addr;
  logic [DATA_WIDTH-1:0]           slot_wdata;
  logic [NUM_SLOTS*DATA_WIDTH-1:0] slot_rdata;
  logic [NUM_SLOTS-1:0]            slot_ack;

  // The bridge itself
  modport slave (
    input  ce, rw, periph_address, reg_address, data_in, slot_rdata, slot_ack,
    output data_out, cpu_ready, bus_err, slot_ce, slot_rw, slot_reg_addr, slot_wdata
  );

  // CPU plus peripheral slots as seen from outside the bridge
  modport master (
    output ce, rw, periph_address, reg_address, data_in, slot_rdata, slot_ack,
    input  data_out, cpu_ready, bus_err, slot_ce, slot_rw, slot_reg_addr, slot_wdata
  );
endinterface

// File: rtl/periph_bus_bridge.sv
// CPU-to-peripheral bridge: registers an access, one-hot selects a slot, returns registered data.
// Latency: slot_ce rises one edge after ce is latched; cpu_ready pulses one edge after ack/timeout/decode.
// Backpressure: slots stall via slot_ack up to TIMEOUT_CYCLES; ce must drop before the next access starts.
module periph_bus_bridge #(
  parameter int NUM_SLOTS      = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int SLOT_MASK      = 'hFF,
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic                clk,
  input logic                rst,
  periph_bus_bridge_if.slave bus
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  // Populated slots over the full 4-bit address space; bits at or above NUM_SLOTS
  // (including the reserved status address) are forced clear.
  localparam logic [15:0] POP_MASK = 16'(SLOT_MASK) & 16'((1 << NUM_SLOTS) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_ACCESS, S_ERROR, S_STATUS, S_DONE
  } state_t;

  state_t                  state;
  logic [3:0]              sel_q;
  logic [3:0]              reg_q;
  logic                    rw_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [TW-1:0]           tcount;
  logic                    timeout_q;
  logic [7:0]              err_count;
  logic [3:0]              last_slot;
  logic                    last_wr;
  logic                    last_timeout;
  logic [DATA_WIDTH-1:0]   data_out_q;
  logic                    cpu_ready_q;
  logic                    bus_err_q;
  logic [NUM_SLOTS-1:0]    slot_ce_q;

  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    sel_ack;
  logic [NUM_SLOTS-1:0]    sel_onehot;

  assign bus.data_out      = data_out_q;
  assign bus.cpu_ready     = cpu_ready_q;
  assign bus.bus_err       = bus_err_q;
  assign bus.slot_ce       = slot_ce_q;
  assign bus.slot_rw       = rw_q;
  assign bus.slot_reg_addr = reg_q;
  assign bus.slot_wdata    = wdata_q;

  // Registered-mux front end: pick ack/rdata of the latched slot and build its one-hot select
  always_comb begin
    sel_rdata  = '0;
    sel_ack    = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (sel_q == 4'(i)) begin
        sel_rdata     = bus.slot_rdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_ack       = bus.slot_ack[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Access sequencer with registered outputs and bridge status logging
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      sel_q        <= '0;
      reg_q        <= '0;
      rw_q         <= 1'b0;
      wdata_q      <= '0;
      tcount       <= '0;
      timeout_q    <= 1'b0;
      err_count    <= '0;
      last_slot    <= '0;
      last_wr      <= 1'b0;
      last_timeout <= 1'b0;
      data_out_q   <= '0;
      cpu_ready_q  <= 1'b0;
      bus_err_q    <= 1'b0;
      slot_ce_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.ce) begin
            sel_q   <= bus.periph_address;
            reg_q   <= bus.reg_address;
            rw_q    <= bus.rw;
            wdata_q <= bus.data_in;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          tcount <= '0;
          if (POP_MASK[sel_q]) begin
            slot_ce_q <= sel_onehot;
            state     <= S_ACCESS;
          end else if (sel_q == 4'hF) begin
            state <= S_STATUS;
          end else begin
            timeout_q <= 1'b0;
            state     <= S_ERROR;
          end
        end
        S_ACCESS: begin
          // Ack is checked first so an ack in the final allowed cycle still succeeds
          if (sel_ack) begin
            slot_ce_q   <= '0;
            cpu_ready_q <= 1'b1;
            data_out_q  <= rw_q ? '0 : sel_rdata;
            state       <= S_DONE;
          end else if (tcount == T_LAST) begin
            slot_ce_q <= '0;
            timeout_q <= 1'b1;
            state     <= S_ERROR;
          end else begin
            tcount <= tcount + 1'b1;
          end
        end
        S_ERROR: begin
          cpu_ready_q  <= 1'b1;
          data_out_q   <= '0;
          bus_err_q    <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          last_slot    <= sel_q;
          last_wr      <= rw_q;
          last_timeout <= timeout_q;
          state        <= S_DONE;
        end
        S_STATUS: begin
          cpu_ready_q <= 1'b1;
          if (rw_q) begin
            data_out_q   <= '0;
            bus_err_q    <= 1'b0;
            err_count    <= '0;
            last_slot    <= '0;
            last_wr      <= 1'b0;
            last_timeout <= 1'b0;
          end else begin
            data_out_q <= DATA_WIDTH'({last_slot, last_wr, last_timeout, 2'b00, err_count});
          end
          state <= S_DONE;
        end
        S_DONE: begin
          // A held ce parks here so it can never launch a second access
          cpu_ready_q <= 1'b0;
          data_out_q  <= '0;
          if (!bus.ce) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Bench for periph_bus_bridge: directed scenarios plus randomized accesses vs a transaction model.
// Latency: measured in clock edges from the edge that samples ce.
// Backpressure: slot acks are generated after a chosen number of slot_ce cycles, or never.
module tb_periph_bus_bridge;
  localparam int NUM_SLOTS = 8;
  localparam int DW        = 32;
  localparam int TIMEOUT   = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  periph_bus_bridge_if #(.NUM_SLOTS(NUM_SLOTS), .DATA_WIDTH(DW)) bus ();

  periph_bus_bridge #(
    .NUM_SLOTS(NUM_SLOTS), .DATA_WIDTH(DW), .SLOT_MASK('hFF), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] slot_mem [NUM_SLOTS];

  // Reference model of the bridge status register
  bit m_err;
  int m_count;
  int m_slot;
  bit m_wr;
  bit m_to;

  function automatic logic [31:0] m_status();
    return 32'((m_slot << 12) | (int'(m_wr) << 11) | (int'(m_to) << 10) | m_count);
  endfunction

  task automatic m_log(input int addr, input bit wr, input bit to);
    m_err = 1'b1;
    if (m_count < 255) m_count++;
    m_slot = addr;
    m_wr   = wr;
    m_to   = to;
  endtask

  // Expected outcome of one access: slot_ce cycles, edge of cpu_ready, returned data
  task automatic model_access(input int addr, input bit wr, input int ack_wait,
                              output int e_sce, output int e_edge, output logic [31:0] e_data);
    if (addr < NUM_SLOTS) begin
      if (ack_wait >= 0 && ack_wait < TIMEOUT) begin
        e_sce  = ack_wait + 1;
        e_edge = ack_wait + 2;
        e_data = wr ? 32'h0 : slot_mem[addr];
      end else begin
        e_sce  = TIMEOUT;
        e_edge = TIMEOUT + 2;
        e_data = 32'h0;
        m_log(addr, wr, 1'b1);
      end
    end else if (addr == 15) begin
      e_sce  = 0;
      e_edge = 2;
      e_data = wr ? 32'h0 : m_status();
      if (wr) begin
        m_err = 0; m_count = 0; m_slot = 0; m_wr = 0; m_to = 0;
      end
    end else begin
      e_sce  = 0;
      e_edge = 2;
      e_data = 32'h0;
      m_log(addr, wr, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ce = 1'b0; bus.rw = 1'b0; bus.periph_address = '0; bus.reg_address = '0;
    bus.data_in = '0; bus.slot_ack = '0; bus.slot_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_err = 0; m_count = 0; m_slot = 0; m_wr = 0; m_to = 0;
  endtask

  task automatic fill_mem();
    for (int s = 0; s < NUM_SLOTS; s++) slot_mem[s] = $urandom;
  endtask

  // Drive one CPU access and act as the slots; 30 edges, bounded
  task automatic run_access(input logic [3:0] addr, input logic wr, input int ack_wait,
                            input int hold, input int drop_at,
                            output int sce_cyc, output int proto_bad, output int rdy_cnt,
                            output int rdy_edge, output logic [31:0] rdata_obs);
    logic [3:0]           ra;
    logic [31:0]          wd;
    logic [NUM_SLOTS-1:0] sel_mask;
    logic [NUM_SLOTS-1:0] ack;
    int                   hi;
    ra = 4'($urandom_range(0, 15));
    wd = $urandom;
    sel_mask = (addr < NUM_SLOTS) ? (NUM_SLOTS'(1) << addr) : '0;
    sce_cyc = 0; proto_bad = 0; rdy_cnt = 0; rdy_edge = -1; rdata_obs = '0; hi = 0;
    for (int s = 0; s < NUM_SLOTS; s++) bus.slot_rdata[s*DW +: DW] = slot_mem[s];
    bus.rw = wr; bus.periph_address = addr; bus.reg_address = ra; bus.data_in = wd;
    bus.ce = 1'b1;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk); #1;
      if (bus.slot_ce !== '0) begin
        sce_cyc++; hi++;
        if (bus.slot_ce !== sel_mask || bus.slot_rw !== wr ||
            bus.slot_reg_addr !== ra || bus.slot_wdata !== wd) proto_bad++;
      end else begin
        hi = 0;
      end
      if (bus.cpu_ready === 1'b1) begin
        rdy_cnt++;
        if (rdy_edge < 0) begin
          rdy_edge  = e;
          rdata_obs = bus.data_out;
        end
      end else if (bus.data_out !== '0) begin
        proto_bad++;
      end
      ack = NUM_SLOTS'($urandom) & ~sel_mask;
      if (hi > 0 && hi == ack_wait + 1) ack = ack | sel_mask;
      bus.slot_ack = ack;
      if ((rdy_edge >= 0 && e >= hold) || e >= drop_at) bus.ce = 1'b0;
    end
    bus.ce = 1'b0;
    bus.slot_ack = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.cpu_ready !== 1'b0 || bus.data_out !== '0) begin
      n_fail++; $display("FAIL reset_cpu_side: ready=%b data=%h, need 0/0", bus.cpu_ready, bus.data_out);
    end
    n_checks++;
    if (bus.bus_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_bus_err: got %b need 0", bus.bus_err);
    end
    n_checks++;
    if (bus.slot_ce !== '0 || bus.slot_rw !== 1'b0 || bus.slot_reg_addr !== '0 || bus.slot_wdata !== '0) begin
      n_fail++; $display("FAIL reset_slot_side: ce=%h rw=%b ra=%h wd=%h, need all 0",
                         bus.slot_ce, bus.slot_rw, bus.slot_reg_addr, bus.slot_wdata);
    end
  endtask

  task automatic test_zero_wait();
    int sc, pb, rc, re, es, ee;
    logic [31:0] d, ed;
    fill_mem();
    slot_mem[2] = 32'hCAFE_0002;
    model_access(2, 1'b0, 0, es, ee, ed);
    run_access(4'd2, 1'b0, 0, 0, 99, sc, pb, rc, re, d);
    n_checks++;
    if (sc !== 1 || pb !== 0) begin
      n_fail++; $display("FAIL zero_wait_slot_ce: high %0d cycles, %0d bad, need 1 and 0", sc, pb);
    end
    n_checks++;
    if (rc !== 1 || re !== 2) begin
      n_fail++; $display("FAIL zero_wait_ready: %0d pulses at edge %0d, need 1 at edge 2", rc, re);
    end
    n_checks++;
    if (d !== 32'hCAFE_0002) begin
      n_fail++; $display("FAIL zero_wait_data: got %h need cafe0002", d);
    end
    n_checks++;
    if (bus.bus_err !== 1'b0) begin
      n_fail++; $display("FAIL zero_wait_err: got %b need 0", bus.bus_err);
    end
  endtask

  task automatic test_wait_states();
    int sc, pb, rc, re, es, ee;
    logic [31:0] d, ed;
    fill_mem();
    model_access(0, 1'b0, 5, es, ee, ed);
    run_access(4'd0, 1'b0, 5, 0, 99, sc, pb, rc, re, d);
    n_checks++;
    if (rc !== 1 || re - 1 !== 6 || sc !== 6 || pb !== 0) begin
      n_fail++; $display("FAIL wait_states_timing: ready %0d at edge %0d, slot_ce %0d cycles, bad %0d, need 1/7/6/0",
                         rc, re, sc, pb);
    end
    n_checks++;
    if (d !== slot_mem[0] || bus.bus_err !== 1'b0) begin
      n_fail++; $display("FAIL wait_states_data: data %h err %b, need %h/0", d, bus.bus_err, slot_mem[0]);
    end
  endtask

  task automatic test_timeout();
    int sc, pb, rc, re, es, ee;
    logic [31:0] d, ed;
    do_reset();
    fill_mem();
    model_access(1, 1'b1, -1, es, ee, ed);
    run_access(4'd1, 1'b1, -1, 0, 99, sc, pb, rc, re, d);
    n_checks++;
    if (sc !== 15 || pb !== 0) begin
      n_fail++; $display("FAIL timeout_slot_ce: high %0d cycles, %0d bad, need 15 and 0", sc, pb);
    end
    n_checks++;
    if (rc !== 1 || re !== 17 || d !== 32'h0 || bus.bus_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_ready: %0d pulses edge %0d data %h err %b, need 1/17/0/1",
                         rc, re, d, bus.bus_err);
    end
    model_access(15, 1'b0, -1, es, ee, ed);
    run_access(4'hF, 1'b0, -1, 0, 99, sc, pb, rc, re, d);
    n_checks++;
    if (d !== 32'h0000_1C01 || re !== 2) begin
      n_fail++; $display("FAIL timeout_status: got %h at edge %0d, need 00001c01 at edge 2", d, re);
    end
  endtask

  task automatic test_unmapped();
    int sc, pb, rc, re, es, ee;
    logic [31:0] d, ed;
    do_reset();
    fill_mem();
    model_access(9, 1'b0, 0, es, ee, ed);
    run_access(4'd9, 1'b0, 0, 0, 99, sc, pb, rc, re, d);
    n_checks++;
    if (sc !== 0 || rc !== 1 || re !== 2 || d !== 32'h0 || bus.bus_err !== 1'b1) begin
      n_fail++; $display("FAIL unmapped_read: slot_ce %0d, %0d pulses edge %0d, data %h, err %b, need 0/1/2/0/1",
                         sc, rc, re, d, bus.bus_err);
    end
    model_access(15, 1'b0, -1, es, ee, ed);
    run_access(4'hF, 1'b0, -1, 0, 99, sc, pb, rc, re, d);
    n_checks++;
    if (d !== 32'h0000_9001) begin
      n_fail++; $display("FAIL unmapped_status: got %h need 00009001", d);
    end
    model_access(15, 1'b1, -1, es, ee, ed);
    run_access(4'hF, 1'b1, -1, 0, 99, sc, pb, rc, re, d);
    n_checks++;
    if (bus.bus_err !== 1'b0 || rc !== 1) begin
      n_fail++; $display("FAIL status_clear_err: err %b, %0d pulses, need 0 and 1", bus.bus_err, rc);
    end
    model_access(15, 1'b0, -1, es, ee, ed);
    run_access(4'hF, 1'b0, -1, 0, 99, sc, pb, rc, re, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL status_after_clear: got %h need 0", d);
    end
  endtask

  task automatic test_held_ce();
    int sc, pb, rc, re, es, ee;
    logic [31:0] d, ed;
    fill_mem();
    model_access(3, 1'b0, 0, es, ee, ed);
    run_access(4'd3, 1'b0, 0, 10, 99, sc, pb, rc, re, d);
    n_checks++;
    if (sc !== 1 || rc !== 1 || d !== slot_mem[3]) begin
      n_fail++; $display("FAIL held_ce: slot_ce %0d cycles, %0d ready pulses, data %h, need 1/1/%h",
                         sc, rc, d, slot_mem[3]);
    end
  endtask

  task automatic test_ack_at_timeout();
    int sc, pb, rc, re, es, ee;
    logic [31:0] d, ed;
    do_reset();
    fill_mem();
    model_access(4, 1'b0, 14, es, ee, ed);
    run_access(4'd4, 1'b0, 14, 0, 99, sc, pb, rc, re, d);
    n_checks++;
    if (sc !== 15 || rc !== 1 || re !== 16 || d !== slot_mem[4] || bus.bus_err !== 1'b0) begin
      n_fail++; $display("FAIL ack_at_timeout: slot_ce %0d, %0d pulses edge %0d, data %h, err %b, need 15/1/16/%h/0",
                         sc, rc, re, d, bus.bus_err, slot_mem[4]);
    end
  endtask

  task automatic test_saturation();
    int sc, pb, rc, re, es, ee;
    logic [31:0] d, ed;
    logic [3:0] a;
    logic w;
    do_reset();
    fill_mem();
    for (int i = 0; i < 300; i++) begin
      a = 4'(8 + $urandom_range(0, 6));
      w = 1'($urandom_range(0, 1));
      model_access(int'(a), w, 0, es, ee, ed);
      run_access(a, w, 0, 0, 99, sc, pb, rc, re, d);
    end
    model_access(15, 1'b0, -1, es, ee, ed);
    run_access(4'hF, 1'b0, -1, 0, 99, sc, pb, rc, re, d);
    n_checks++;
    if (d[7:0] !== 8'hFF || d !== ed) begin
      n_fail++; $display("FAIL saturation_status: got %h need %h (count ff)", d, ed);
    end
  endtask

  task automatic test_reset_mid_access();
    int sc, pb, rc, re, es, ee, pulses;
    logic [31:0] d, ed;
    fill_mem();
    model_access(10, 1'b0, 0, es, ee, ed);
    run_access(4'd10, 1'b0, 0, 0, 99, sc, pb, rc, re, d);
    for (int s = 0; s < NUM_SLOTS; s++) bus.slot_rdata[s*DW +: DW] = slot_mem[s];
    bus.slot_ack = '0; bus.rw = 1'b0; bus.periph_address = 4'd0; bus.ce = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (bus.slot_ce !== 8'h01 || bus.bus_err !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_setup: slot_ce %h err %b, need 01/1", bus.slot_ce, bus.bus_err);
    end
    rst = 1'b1; bus.ce = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.slot_ce !== '0 || bus.cpu_ready !== 1'b0 || bus.bus_err !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_access: slot_ce %h ready %b err %b, need 0/0/0",
                         bus.slot_ce, bus.cpu_ready, bus.bus_err);
    end
    rst = 1'b0;
    m_err = 0; m_count = 0; m_slot = 0; m_wr = 0; m_to = 0;
    pulses = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (bus.cpu_ready === 1'b1 || bus.slot_ce !== '0) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL rst_no_ready: %0d cycles of ready/slot_ce after reset, need 0", pulses);
    end
    model_access(15, 1'b0, -1, es, ee, ed);
    run_access(4'hF, 1'b0, -1, 0, 99, sc, pb, rc, re, d);
    n_checks++;
    if (d !== ed) begin
      n_fail++; $display("FAIL rst_status_cleared: got %h need %h", d, ed);
    end
  endtask

  task automatic test_random();
    int sc, pb, rc, re, es, ee, aw, hold, drop, pick;
    logic [31:0] d, ed;
    logic [3:0] a;
    logic w;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      fill_mem();
      pick = $urandom_range(0, 9);
      if (pick < 6)      a = 4'($urandom_range(0, NUM_SLOTS - 1));
      else if (pick < 8) a = 4'($urandom_range(NUM_SLOTS, 14));
      else               a = 4'hF;
      w    = 1'($urandom_range(0, 1));
      aw   = int'($urandom_range(0, 17)) - 1;
      hold = $urandom_range(0, 4);
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : 99;
      model_access(int'(a), w, aw, es, ee, ed);
      run_access(a, w, aw, hold, drop, sc, pb, rc, re, d);
      n_checks++;
      if (sc !== es || pb !== 0) begin
        n_fail++; $display("FAIL rand_slot_ce[%0d]: addr %0d %0d cycles %0d bad, need %0d and 0", i, a, sc, pb, es);
      end
      n_checks++;
      if (rc !== 1 || re !== ee) begin
        n_fail++; $display("FAIL rand_ready[%0d]: addr %0d %0d pulses edge %0d, need 1 at %0d", i, a, rc, re, ee);
      end
      n_checks++;
      if (d !== ed) begin
        n_fail++; $display("FAIL rand_data[%0d]: addr %0d got %h need %h", i, a, d, ed);
      end
      n_checks++;
      if (bus.bus_err !== m_err) begin
        n_fail++; $display("FAIL rand_err[%0d]: got %b need %b", i, bus.bus_err, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_timeout();
    test_unmapped();
    test_held_ce();
    test_ack_at_timeout();
    test_saturation();
    test_reset_mid_access();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
